ac97_mem_wrap: RTL and testbench

// AC'97 link controller with an on-chip sample memory. It generates AC-link frames (SYNC/SDATA_OUT) towards the codec.
// In record mode it stores incoming PCM slot 3/4 samples into the internal RAM; in play mode it streams them back out.

---
 rtl/ac97_mem_wrap.sv | 159 +++++++++++++++
 tb/tb_ac97_mem_wrap.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac97_mem_wrap.sv
// AC'97 link controller with an on-chip sample RAM.
// Builds AC-link frames; records slot 3/4 PCM into RAM or loops it back out.
module ac97_mem_wrap #(
    parameter int ADDR_W   = 14,
    parameter int SAMPLE_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic AC_97_BIT_CLK,
    input  logic AC97_RST,
    input  logic AC97_SDATA_IN,
    input  logic play,
    input  logic rec,
    input  logic operate,
    output logic AC97_SDATA_OUT,
    output logic AC97_SYNC
);
    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_PLAY,
        MODE_REC
    } mode_t;

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [31:0] ram [0:DEPTH-1];

    logic                link_on;
    logic                run;
    logic [7:0]          bit_cnt;
    logic [7:0]          idx_nx;
    logic                frame_start;
    logic                frame_end;
    mode_t               mode;
    mode_t               mode_nx;
    logic                enter_rec;
    logic                enter_play;
    logic                play_en;
    logic                play_en_nx;
    logic [15:0]         tx_tag;
    logic [15:0]         tag_sel;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     rd_inc;
    logic [ADDR_W:0]     rec_count;
    logic [19:0]         rx_sr;
    logic [15:0]         rx_tag;
    logic [SAMPLE_W-1:0] rx_s3;
    logic [31:0]         rd_word;
    logic                tag_ok;
    logic                wr_en;
    logic                rd_en;
    logic [4:0]          s3_pos;
    logic [4:0]          s4_pos;
    logic                tx_bit;
    logic                bit_clk_unused;

    assign bit_clk_unused = AC_97_BIT_CLK;

    always_comb begin
        link_on     = operate & ~AC97_RST;
        idx_nx      = run ? bit_cnt + 8'd1 : 8'd0;
        frame_start = link_on && (idx_nx == 8'd0);
        frame_end   = link_on && run && (bit_cnt == 8'd255);
        mode_nx     = mode;
        if (frame_start) begin
            if (rec)
                mode_nx = MODE_REC;
            else if (play)
                mode_nx = MODE_PLAY;
            else
                mode_nx = MODE_IDLE;
        end
        enter_rec  = frame_start && (mode_nx == MODE_REC) && (mode != MODE_REC);
        enter_play = frame_start && (mode_nx == MODE_PLAY) && (mode != MODE_PLAY);
        play_en_nx = (mode_nx == MODE_PLAY) && (rec_count != '0);
        tag_sel    = tx_tag;
        if (frame_start)
            tag_sel = play_en_nx ? 16'h9800 : 16'h8000;
        tag_ok = rx_tag[15] & rx_tag[12] & rx_tag[11];
        wr_en  = rst && link_on && run && (bit_cnt == 8'd96) &&
                 (mode == MODE_REC) && tag_ok && !rec_count[ADDR_W];
        rd_en  = link_on && run && (bit_cnt == 8'd1);
        rd_inc = {1'b0, rd_ptr} + CNT_ONE;
        // modulo-32 offsets of slot3/slot4 sample bits within rd_word
        s3_pos = 5'd23 - idx_nx[4:0];
        s4_pos = 5'd27 - idx_nx[4:0];
        tx_bit = 1'b0;
        unique case (1'b1)
            idx_nx < 8'd16:
                tx_bit = tag_sel[~idx_nx[3:0]];
            (idx_nx >= 8'd56) && (idx_nx < 8'd72):
                tx_bit = play_en & rd_word[s3_pos];
            (idx_nx >= 8'd76) && (idx_nx < 8'd92):
                tx_bit = play_en & rd_word[s4_pos];
            default:
                tx_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            run            <= 1'b0;
            bit_cnt        <= '0;
            AC97_SYNC      <= 1'b0;
            AC97_SDATA_OUT <= 1'b0;
            mode           <= MODE_IDLE;
            play_en        <= 1'b0;
            tx_tag         <= 16'h8000;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            rec_count      <= '0;
        end else if (!link_on) begin
            run            <= 1'b0;
            bit_cnt        <= '0;
            AC97_SYNC      <= 1'b0;
            AC97_SDATA_OUT <= 1'b0;
        end else begin
            run            <= 1'b1;
            bit_cnt        <= idx_nx;
            AC97_SYNC      <= idx_nx < 8'd16;
            AC97_SDATA_OUT <= tx_bit;
            if (frame_start) begin
                mode    <= mode_nx;
                play_en <= play_en_nx;
                tx_tag  <= tag_sel;
            end
            if (enter_rec) begin
                wr_ptr    <= '0;
                rec_count <= '0;
            end else if (wr_en) begin
                wr_ptr    <= wr_ptr + CNT_ONE[ADDR_W-1:0];
                rec_count <= rec_count + CNT_ONE;
            end
            if (enter_play)
                rd_ptr <= '0;
            else if (frame_end && play_en)
                rd_ptr <= (rd_inc == rec_count) ? '0 : rd_inc[ADDR_W-1:0];
        end
    end

    // tag, slot3 and slot4 are captured from one running shift register
    always_ff @(posedge clk) begin
        rx_sr <= {rx_sr[18:0], AC97_SDATA_IN};
        if (run && (bit_cnt == 8'd15))
            rx_tag <= {rx_sr[14:0], AC97_SDATA_IN};
        if (run && (bit_cnt == 8'd75))
            rx_s3 <= rx_sr[18:3];
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            ram[wr_ptr] <= {rx_s3, rx_sr[19:4]};
        if (rd_en)
            rd_word <= ram[rd_ptr];
    end

endmodule

// File: tb/tb_ac97_mem_wrap.sv
// Self-checking bench for ac97_mem_wrap.
// Frame-level codec and memory model; randomized sample data.
module tb_ac97_mem_wrap;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst;
    logic ac_rst;
    logic sdin;
    logic play;
    logic rec;
    logic operate;
    logic sdout;
    logic sync;

    int checks;
    int errors;

    int          m_mode;
    int          m_rc;
    int          m_wr;
    int          m_rd;
    logic [31:0] m_mem [DEPTH];
    logic [255:0] sync_pat;

    ac97_mem_wrap #(
        .ADDR_W(ADDR_W),
        .SAMPLE_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .AC_97_BIT_CLK(clk),
        .AC97_RST(ac_rst),
        .AC97_SDATA_IN(sdin),
        .play(play),
        .rec(rec),
        .operate(operate),
        .AC97_SDATA_OUT(sdout),
        .AC97_SYNC(sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] codec_frame(input logic [15:0] tag,
                                                 input logic [19:0] s3,
                                                 input logic [19:0] s4);
        logic [255:0] v;
        for (int k = 0; k < 256; k++) v[k] = 1'($urandom);
        for (int k = 0; k < 16; k++) v[k] = tag[15-k];
        for (int k = 0; k < 20; k++) begin
            v[56+k] = s3[19-k];
            v[76+k] = s4[19-k];
        end
        return v;
    endfunction

    function automatic logic [15:0] pick_tag();
        case ($urandom_range(0, 4))
            0: return 16'h8000;
            1: return 16'h9000;
            2: return 16'h1800;
            3: return 16'hF800;
            default: return 16'h9800;
        endcase
    endfunction

    // mode is 0 idle, 1 play, 2 rec
    task automatic model_start(output logic [255:0] etx);
        int nm;
        logic [15:0] tag;
        logic [31:0] w;
        nm = rec ? 2 : (play ? 1 : 0);
        if (nm == 2 && m_mode != 2) begin
            m_wr = 0;
            m_rc = 0;
        end
        if (nm == 1 && m_mode != 1) m_rd = 0;
        m_mode = nm;
        etx = '0;
        tag = (m_mode == 1 && m_rc > 0) ? 16'h9800 : 16'h8000;
        for (int k = 0; k < 16; k++) etx[k] = tag[15-k];
        if (m_mode == 1 && m_rc > 0) begin
            w = m_mem[m_rd];
            for (int k = 0; k < 16; k++) begin
                etx[56+k] = w[31-k];
                etx[76+k] = w[15-k];
            end
        end
    endtask

    task automatic model_end(input logic [15:0] tag,
                             input logic [19:0] s3,
                             input logic [19:0] s4);
        if (m_mode == 2 && tag[15] && tag[12] && tag[11] && m_rc < DEPTH) begin
            m_mem[m_wr] = {s3[19:4], s4[19:4]};
            m_wr++;
            m_rc++;
        end
        if (m_mode == 1 && m_rc > 0)
            m_rd = (m_rd + 1 == m_rc) ? 0 : m_rd + 1;
    endtask

    task automatic do_frame(input logic [15:0] tag,
                            input logic [19:0] s3,
                            input logic [19:0] s4,
                            output logic [255:0] otx,
                            output logic [255:0] osync,
                            output logic [255:0] etx);
        logic [255:0] rxv;
        model_start(etx);
        rxv = codec_frame(tag, s3, s4);
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            otx[k]   = sdout;
            osync[k] = sync;
            sdin     = rxv[k];
        end
        model_end(tag, s3, s4);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        operate = 1'b0;
        ac_rst = 1'b0;
        play = 1'b0;
        rec = 1'b0;
        sdin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sync !== 1'b0) begin
            errors++;
            $display("FAIL reset_sync: got %b expected 0", sync);
        end
        checks++;
        if (sdout !== 1'b0) begin
            errors++;
            $display("FAIL reset_sdout: got %b expected 0", sdout);
        end
        checks++;
        if (dut.rec_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_rec_count: got %0d expected 0", dut.rec_count);
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (sync !== 1'b0 || sdout !== 1'b0) begin
                errors++;
                $display("FAIL idle_link cycle %0d: sync=%b sdout=%b expected 0/0",
                         i, sync, sdout);
            end
        end
    endtask

    task automatic test_idle_framing();
        logic [255:0] otx, osync, etx;
        operate = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_frame(pick_tag(), 20'($urandom), 20'($urandom), otx, osync, etx);
            checks++;
            if (otx !== 256'h1) begin
                errors++;
                $display("FAIL idle_sdout frame %0d: got %h expected %h", i, otx, 256'h1);
            end
            checks++;
            if (osync !== sync_pat) begin
                errors++;
                $display("FAIL idle_sync frame %0d: got %h expected %h", i, osync, sync_pat);
            end
        end
    endtask

    task automatic test_record();
        logic [255:0] otx, osync, etx;
        logic [15:0] tag;
        rec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tag = (i < 3) ? 16'h9800 : 16'h8000;
            do_frame(tag, 20'hABCD0, 20'h12340, otx, osync, etx);
            checks++;
            if (otx !== etx) begin
                errors++;
                $display("FAIL rec_sdout frame %0d: got %h expected %h", i, otx, etx);
            end
            checks++;
            if (osync !== sync_pat) begin
                errors++;
                $display("FAIL rec_sync frame %0d: got %h expected %h", i, osync, sync_pat);
            end
        end
        checks++;
        if (dut.rec_count !== 3'd3) begin
            errors++;
            $display("FAIL rec_count: got %0d expected 3", dut.rec_count);
        end
        for (int a = 0; a < 3; a++) begin
            checks++;
            if (dut.ram[a] !== 32'hABCD1234) begin
                errors++;
                $display("FAIL rec_ram[%0d]: got %h expected abcd1234", a, dut.ram[a]);
            end
        end
    endtask

    task automatic test_play(input string name, input int n);
        logic [255:0] otx, osync, etx;
        rec = 1'b0;
        play = 1'b1;
        for (int i = 0; i < n; i++) begin
            do_frame(pick_tag(), 20'($urandom), 20'($urandom), otx, osync, etx);
            checks++;
            if (otx !== etx) begin
                errors++;
                $display("FAIL %s_sdout frame %0d: got %h expected %h", name, i, otx, etx);
            end
            checks++;
            if (osync !== sync_pat) begin
                errors++;
                $display("FAIL %s_sync frame %0d: got %h expected %h", name, i, osync, sync_pat);
            end
        end
    endtask

    task automatic test_random_record();
        logic [255:0] otx, osync, etx;
        logic [15:0] tag;
        rec = 1'b1;
        play = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tag = (i == 0) ? 16'h9800 : pick_tag();
            do_frame(tag, 20'($urandom), 20'($urandom), otx, osync, etx);
            checks++;
            if (otx !== etx) begin
                errors++;
                $display("FAIL rnd_rec_sdout frame %0d: got %h expected %h", i, otx, etx);
            end
        end
        checks++;
        if (dut.rec_count !== 3'(m_rc)) begin
            errors++;
            $display("FAIL rnd_rec_count: got %0d expected %0d", dut.rec_count, m_rc);
        end
    endtask

    task automatic test_full();
        logic [255:0] otx, osync, etx;
        logic [31:0] first;
        logic [19:0] s3, s4;
        rec = 1'b1;
        play = 1'b0;
        first = '0;
        for (int i = 0; i < 6; i++) begin
            s3 = 20'($urandom);
            s4 = 20'($urandom);
            if (i == 0) first = {s3[19:4], s4[19:4]};
            do_frame(16'h9800, s3, s4, otx, osync, etx);
            checks++;
            if (otx !== etx) begin
                errors++;
                $display("FAIL full_sdout frame %0d: got %h expected %h", i, otx, etx);
            end
        end
        checks++;
        if (dut.rec_count !== 3'd4) begin
            errors++;
            $display("FAIL full_rec_count: got %0d expected 4", dut.rec_count);
        end
        checks++;
        if (dut.ram[0] !== first) begin
            errors++;
            $display("FAIL full_ram0: got %h expected %h", dut.ram[0], first);
        end
    endtask

    task automatic test_priority();
        logic [255:0] otx, osync, etx;
        rec = 1'b1;
        play = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_frame(16'h9800, 20'($urandom), 20'($urandom), otx, osync, etx);
            checks++;
            if (otx !== etx || otx[15:0] !== 16'h0001) begin
                errors++;
                $display("FAIL prio_sdout frame %0d: got %h expected %h", i, otx, etx);
            end
        end
    endtask

    task automatic test_play_empty();
        logic [255:0] otx, osync, etx;
        rec = 1'b0;
        play = 1'b0;
        do_frame(16'h9800, 20'($urandom), 20'($urandom), otx, osync, etx);
        rec = 1'b1;
        do_frame(16'h8000, 20'($urandom), 20'($urandom), otx, osync, etx);
        checks++;
        if (dut.rec_count !== 3'd0) begin
            errors++;
            $display("FAIL empty_rec_count: got %0d expected 0", dut.rec_count);
        end
        rec = 1'b0;
        play = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_frame(16'h9800, 20'($urandom), 20'($urandom), otx, osync, etx);
            checks++;
            if (otx !== etx || otx !== 256'h1) begin
                errors++;
                $display("FAIL empty_play_sdout frame %0d: got %h expected %h", i, otx, etx);
            end
        end
    endtask

    task automatic test_link_drop();
        logic [255:0] otx, osync, etx, rxv;
        rec = 1'b1;
        play = 1'b0;
        model_start(etx);
        rxv = codec_frame(16'h9800, 20'($urandom), 20'($urandom));
        otx = '0;
        osync = '0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            otx[k]   = sdout;
            osync[k] = sync;
            sdin     = rxv[k];
        end
        checks++;
        if (otx[40:0] !== etx[40:0] || osync[40:0] !== sync_pat[40:0]) begin
            errors++;
            $display("FAIL drop_partial: sdout %h sync %h expected %h %h",
                     otx[40:0], osync[40:0], etx[40:0], sync_pat[40:0]);
        end
        ac_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (sync !== 1'b0 || sdout !== 1'b0) begin
            errors++;
            $display("FAIL drop_outputs: sync=%b sdout=%b expected 0/0", sync, sdout);
        end
        repeat (4) @(negedge clk);
        ac_rst = 1'b0;
        do_frame(16'h8000, 20'($urandom), 20'($urandom), otx, osync, etx);
        checks++;
        if (otx !== etx || osync !== sync_pat) begin
            errors++;
            $display("FAIL drop_restart: sdout %h sync %h expected %h %h",
                     otx, osync, etx, sync_pat);
        end
        checks++;
        if (dut.rec_count !== 3'(m_rc) || m_rc != 0) begin
            errors++;
            $display("FAIL drop_rec_count: got %0d expected 0", dut.rec_count);
        end
        do_frame(16'h9800, 20'($urandom), 20'($urandom), otx, osync, etx);
        checks++;
        if (dut.rec_count !== 3'd1 || dut.ram[0] !== m_mem[0]) begin
            errors++;
            $display("FAIL drop_next_write: count %0d ram0 %h expected 1 %h",
                     dut.rec_count, dut.ram[0], m_mem[0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_mode = 0;
        m_rc = 0;
        m_wr = 0;
        m_rd = 0;
        sync_pat = 256'hFFFF;
        test_reset();
        test_idle_framing();
        test_record();
        test_play("play", 7);
        test_random_record();
        test_play("rnd_play", 6);
        test_full();
        test_play("full_play", 5);
        test_priority();
        test_play_empty();
        test_link_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
